cfg_rd_arbiter: RTL and testbench
=================================

Name: cfg_rd_arbiter

Overview:
- Shares the single read port of one cfg_ram configuration table between NUM_REQ parser stages.
- Each requester posts a burst request of 1..2^LEN_WIDTH consecutive words.
- The arbiter grants requesters round-robin and drives cfg_ram's address one word per cycle.
- It tags each returned word with requester id and last flag, aligned to the RAM read latency.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_WIDTH, 2, width of rsp_id; must satisfy 2^ID_WIDTH >= NUM_REQ.
- ADDR_WIDTH, 4, cfg_ram address width.
- DATA_WIDTH, 32, cfg_ram data width.
- LEN_WIDTH, 3, burst length field width; encodes words minus 1.
- RD_LATENCY, 1, cycles from ram_addr to valid ram_dout (1..4).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  NUM_REQ  per-requester request pending.
- req_addr  in  NUM_REQ*ADDR_WIDTH  burst base address; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_len  in  NUM_REQ*LEN_WIDTH  burst words minus 1; same slicing as req_addr.
- req_ready  out  NUM_REQ  one-hot accept pulse.
- ram_addr  out  ADDR_WIDTH  to cfg_ram addr; registered.
- ram_dout  in  DATA_WIDTH  from cfg_ram dout.
- rsp_valid  out  1  returned word valid.
- rsp_id  out  ID_WIDTH  requester index of the word.
- rsp_data  out  DATA_WIDTH  returned word.
- rsp_last  out  1  final word of the burst.
- busy  out  1  state is BURST, or any word is still in flight.

Behaviour:
- Reset (rst_n low, async): state IDLE, rr_ptr 0, ram_addr 0, req_ready 0, rsp_valid 0, rsp_id 0, rsp_data 0, rsp_last 0, busy 0, latency pipeline cleared.
- Reset mid-burst aborts the burst. No further responses are produced for it.
- FSM states: IDLE and BURST.
- IDLE, no req_valid: stay in IDLE. req_ready is 0.
- IDLE, any req_valid: grant g = first set req_valid searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[g] = 1 combinationally this cycle, only in IDLE.
  - On the clock edge: ram_addr <= req_addr[g], cnt <= req_len[g], gid <= g, rr_ptr <= (g+1) mod NUM_REQ, state <= BURST.
- BURST: each cycle is one issue cycle with id gid and last = (cnt==0).
  - If cnt != 0: ram_addr <= ram_addr+1 (wraps modulo 2^ADDR_WIDTH), cnt <= cnt-1.
  - Else: state <= IDLE; ram_addr holds its value.
- Requester contract: hold req_valid, req_addr and req_len stable until req_ready. req_valid dropped before grant is not tracked.
- Latency pipeline: shift register RD_LATENCY deep carrying {valid, id, last}, loaded each cycle from the BURST issue.
  - Pipeline tail drives rsp_valid, rsp_id and rsp_last combinationally. rsp_data = ram_dout gated to 0 when the tail is invalid.
  - First word of a burst accepted at cycle T: ram_addr = base during T+1, rsp_valid at T+1+RD_LATENCY. Later words follow on consecutive cycles.
- Throughput: one IDLE cycle between bursts. A burst of L+1 words accepted at T lets the next accept happen at T+L+2.
- No response backpressure: consumers must sink one word per cycle.
- Fairness: a requester waits at most NUM_REQ-1 bursts. req_valid on a non-granted requester during BURST has no effect until the next IDLE.
- Widths: cnt is LEN_WIDTH bits. rsp_id is zero-extended when NUM_REQ < 2^ID_WIDTH.

Test Plan:
- Single request, req 2 addr 5 len 2, rr_ptr 0 → req_ready=0100 at T; ram_addr 5,6,7 at T+1..T+3; rsp_valid T+2..T+4 with id 2, data = ROM[5..7], rsp_last only at T+4; busy low after T+4.
- All four req_valid held high, len 0 each, back-to-back → grant order 0,1,2,3,0; accepts every 2 cycles; each response carries its matching id.
- Address wrap: ADDR_WIDTH 4, addr 14, len 3 → ram_addr 14,15,0,1; data ROM[14],ROM[15],ROM[0],ROM[1].
- Max burst: len 7 (all ones), RD_LATENCY 3 → 8 consecutive rsp_valid cycles; first at T+4; rsp_last on the 8th.
- Reset asserted mid-burst (after 2 of 5 words issued) → all outputs 0 immediately; no further rsp_valid; after release, a pending req 1 is granted first (rr_ptr 0, req 0 idle).
- req 3 asserted during another requester's BURST → no req_ready until the next IDLE cycle; then granted if it is first from rr_ptr.

Source files
------------

// File: rtl/cfg_rd_arbiter.sv
// Round-robin burst read arbiter sharing one cfg_ram read port between NUM_REQ
// requesters; tags returned words with requester id and last flag.
module cfg_rd_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_WIDTH   = 2,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 3,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_len,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [ADDR_WIDTH-1:0]           ram_addr,
  input  logic [DATA_WIDTH-1:0]           ram_dout,
  output logic                            rsp_valid,
  output logic [ID_WIDTH-1:0]             rsp_id,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic                            rsp_last,
  output logic                            busy
);

  typedef enum logic {IDLE, BURST} state_e;

  state_e                  state_q;
  logic [ID_WIDTH-1:0]     rr_ptr_q;
  logic [ID_WIDTH-1:0]     gid_q;
  logic [LEN_WIDTH-1:0]    cnt_q;
  logic [ADDR_WIDTH-1:0]   ram_addr_q;

  logic                    pv_q    [RD_LATENCY];
  logic [ID_WIDTH-1:0]     pid_q   [RD_LATENCY];
  logic                    plast_q [RD_LATENCY];

  logic                    hi_found, lo_found, gnt_any;
  logic [ID_WIDTH-1:0]     hi_idx, lo_idx, gnt_idx, rr_next;
  logic [ADDR_WIDTH-1:0]   hi_addr, lo_addr, gnt_addr;
  logic [LEN_WIDTH-1:0]    hi_len, lo_len, gnt_len;

  // Rotating priority split in two passes: first valid at or above rr_ptr,
  // otherwise the first valid below it (the wrapped part of the search).
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    hi_addr  = '0;
    lo_addr  = '0;
    hi_len   = '0;
    lo_len   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i]) begin
        if (ID_WIDTH'(i) >= rr_ptr_q) begin
          if (!hi_found) begin
            hi_found = 1'b1;
            hi_idx   = ID_WIDTH'(i);
            hi_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            hi_len   = req_len[i*LEN_WIDTH +: LEN_WIDTH];
          end
        end else if (!lo_found) begin
          lo_found = 1'b1;
          lo_idx   = ID_WIDTH'(i);
          lo_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          lo_len   = req_len[i*LEN_WIDTH +: LEN_WIDTH];
        end
      end
    end
    gnt_any  = hi_found | lo_found;
    gnt_idx  = hi_found ? hi_idx  : lo_idx;
    gnt_addr = hi_found ? hi_addr : lo_addr;
    gnt_len  = hi_found ? hi_len  : lo_len;
    rr_next  = (gnt_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_WIDTH'(1);
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && state_q == IDLE && gnt_any) begin
      req_ready = NUM_REQ'(1) << gnt_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      gid_q      <= '0;
      cnt_q      <= '0;
      ram_addr_q <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        pv_q[i]    <= 1'b0;
        pid_q[i]   <= '0;
        plast_q[i] <= 1'b0;
      end
    end else begin
      // Idle cycles load an all-zero slot so the tail reads as id 0 / last 0.
      pv_q[0]    <= (state_q == BURST);
      pid_q[0]   <= (state_q == BURST) ? gid_q : '0;
      plast_q[0] <= (state_q == BURST) && (cnt_q == '0);
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        pv_q[i]    <= pv_q[i-1];
        pid_q[i]   <= pid_q[i-1];
        plast_q[i] <= plast_q[i-1];
      end

      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            ram_addr_q <= gnt_addr;
            cnt_q      <= gnt_len;
            gid_q      <= gnt_idx;
            rr_ptr_q   <= rr_next;
            state_q    <= BURST;
          end
        end
        BURST: begin
          if (cnt_q != '0) begin
            ram_addr_q <= ram_addr_q + ADDR_WIDTH'(1);
            cnt_q      <= cnt_q - LEN_WIDTH'(1);
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q == BURST);
    for (int unsigned i = 0; i < RD_LATENCY; i++) begin
      busy = busy | pv_q[i];
    end
  end

  assign ram_addr  = ram_addr_q;
  assign rsp_valid = pv_q[RD_LATENCY-1];
  assign rsp_id    = pid_q[RD_LATENCY-1];
  assign rsp_last  = plast_q[RD_LATENCY-1];
  assign rsp_data  = pv_q[RD_LATENCY-1] ? ram_dout : '0;

endmodule

// File: tb/tb_cfg_rd_arbiter.sv
// Bench for cfg_rd_arbiter: two instances (read latency 1 and 3) against a
// burst-schedule reference model, directed scenarios then random traffic.
module tb_cfg_rd_arbiter;

  localparam int N    = 4;
  localparam int AW   = 4;
  localparam int DW   = 32;
  localparam int LW   = 3;
  localparam int IW   = 2;
  localparam int MAXC = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*LW-1:0] req_len;

  logic [N-1:0]  rdy0, rdy1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] dout0, dout1, rd0, rd1;
  logic          rv0, rv1, rl0, rl1, busy0, busy1;
  logic [IW-1:0] rid0, rid1;

  logic [DW-1:0] rom [16];
  logic [AW-1:0] sh0;
  logic [AW-1:0] sh1 [3];

  always @(posedge clk) begin
    sh0    <= addr0;
    sh1[0] <= addr1;
    sh1[1] <= sh1[0];
    sh1[2] <= sh1[1];
  end
  assign dout0 = rom[sh0];
  assign dout1 = rom[sh1[2]];

  cfg_rd_arbiter #(.NUM_REQ(N), .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                   .LEN_WIDTH(LW), .RD_LATENCY(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_len(req_len), .req_ready(rdy0), .ram_addr(addr0), .ram_dout(dout0),
    .rsp_valid(rv0), .rsp_id(rid0), .rsp_data(rd0), .rsp_last(rl0), .busy(busy0));

  cfg_rd_arbiter #(.NUM_REQ(N), .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                   .LEN_WIDTH(LW), .RD_LATENCY(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_len(req_len), .req_ready(rdy1), .ram_addr(addr1), .ram_dout(dout1),
    .rsp_valid(rv1), .rsp_id(rid1), .rsp_data(rd1), .rsp_last(rl1), .busy(busy1));

  // Reference model: each accepted burst is expanded into a per-cycle issue schedule.
  bit iv    [MAXC];
  int iid   [MAXC];
  bit ilast [MAXC];
  int iaddr [MAXC];
  int m_free, m_rr, m_addr, cyc;
  int tests, fails;
  int exp_ready, last_grant;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic post(input int i, input int a, input int l);
    req_valid[i]          = 1'b1;
    req_addr[i*AW +: AW]  = AW'(a);
    req_len[i*LW +: LW]   = LW'(l);
  endtask

  task automatic chk_rsp(input string nm, input int L, input logic rv, input logic [IW-1:0] rid,
                         input logic [DW-1:0] rd, input logic rl, input logic bsy);
    int idx;
    logic ev, el, eb;
    logic [IW-1:0] eid;
    logic [DW-1:0] ed;
    idx = cyc - L;
    ev = 1'b0; el = 1'b0; eid = '0; ed = '0;
    if (idx >= 0 && iv[idx]) begin
      ev  = 1'b1;
      el  = ilast[idx];
      eid = IW'(iid[idx]);
      ed  = rom[iaddr[idx]];
    end
    eb = 1'b0;
    for (int d = 0; d <= L; d++) if (cyc - d >= 0 && iv[cyc-d]) eb = 1'b1;
    chk({nm, "_rsp_valid"}, 64'(rv),  64'(ev));
    chk({nm, "_rsp_id"},    64'(rid), 64'(eid));
    chk({nm, "_rsp_data"},  64'(rd),  64'(ed));
    chk({nm, "_rsp_last"},  64'(rl),  64'(el));
    chk({nm, "_busy"},      64'(bsy), 64'(eb));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready_l1"}, 64'(rdy0), 64'd0);
    chk({tag, "_ready_l3"}, 64'(rdy1), 64'd0);
    chk({tag, "_addr_l1"},  64'(addr0), 64'd0);
    chk({tag, "_addr_l3"},  64'(addr1), 64'd0);
    chk({tag, "_out_l1"},   64'({rv0, rid0, rd0, rl0, busy0}), 64'd0);
    chk({tag, "_out_l3"},   64'({rv1, rid1, rd1, rl1, busy1}), 64'd0);
  endtask

  task automatic step();
    int g, len, base, c;
    @(negedge clk);
    exp_ready = 0;
    if (cyc >= m_free && req_valid != '0) begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        c = (m_rr + k) % N;
        if (g < 0 && req_valid[c]) g = c;
      end
      len  = int'(req_len[g*LW +: LW]);
      base = int'(req_addr[g*AW +: AW]);
      for (int j = 0; j <= len; j++) begin
        c = cyc + 1 + j;
        iv[c]    = 1'b1;
        iid[c]   = g;
        ilast[c] = (j == len);
        iaddr[c] = (base + j) % 16;
      end
      m_free     = cyc + len + 2;
      m_rr       = (g + 1) % N;
      exp_ready  = 1 << g;
      last_grant = g;
    end
    if (iv[cyc]) m_addr = iaddr[cyc];
    chk("ready_l1", 64'(rdy0), 64'(exp_ready));
    chk("ready_l3", 64'(rdy1), 64'(exp_ready));
    chk("addr_l1",  64'(addr0), 64'(m_addr));
    chk("addr_l3",  64'(addr1), 64'(m_addr));
    chk_rsp("l1", 1, rv0, rid0, rd0, rl0, busy0);
    chk_rsp("l3", 3, rv1, rid1, rd1, rl1, busy1);
    @(posedge clk);
    #1;
    cyc++;
    if (exp_ready != 0) req_valid[last_grant] = 1'b0;
  endtask

  task automatic model_reset();
    for (int x = 0; x < MAXC; x++) iv[x] = 1'b0;
    m_rr   = 0;
    m_addr = 0;
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0;
    m_free = 0; exp_ready = 0; last_grant = 0;
    model_reset();
    for (int i = 0; i < 16; i++) rom[i] = $urandom;
    rst_n = 1'b0; req_valid = '0; req_addr = '0; req_len = '0;
    repeat (2) @(posedge clk);
    #2;
    chk_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single request: req 2, addr 5, len 2
    post(2, 5, 2);
    repeat (8) step();

    // all four held high with len 0, back-to-back
    for (int i = 0; i < N; i++) post(i, 3 * i, 0);
    repeat (12) begin
      step();
      for (int i = 0; i < N; i++) if (!req_valid[i]) post(i, 3 * i, 0);
    end
    req_valid = '0;
    repeat (5) step();

    // address wrap
    post(0, 14, 3);
    repeat (8) step();

    // maximum burst length
    post(1, 9, 7);
    repeat (13) step();

    // req 3 raised during another requester's burst
    post(0, 2, 4);
    step();
    post(3, 7, 1);
    repeat (10) step();

    // reset after two of five words issued; req 1 and req 3 pending
    post(1, 3, 4);
    repeat (3) step();
    post(1, 8, 1);
    post(3, 0, 0);
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    model_reset();
    @(posedge clk);
    #1;
    cyc++;
    rst_n  = 1'b1;
    m_free = cyc;
    #3;
    chk("post_reset_grant_l1", 64'(rdy0), 64'(4'b0010));
    chk("post_reset_grant_l3", 64'(rdy1), 64'(4'b0010));
    repeat (12) step();

    // random traffic
    repeat (600) begin
      step();
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(99) < 30)
          post(i, int'($urandom_range(15)), int'($urandom_range(7)));
    end
    req_valid = '0;
    repeat (14) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
